image_ctl_regs: RTL



---
 rtl/image_ctl_regs.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/image_ctl_regs.sv
// AXI4-Lite register bank for the image-transfer control path.
// Holds CTRL/WIDTH/HEIGHT and reports live plus sticky pipeline status.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET  clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*           write address, data and response channels
//   S_AXI_AR*/R*              read address and data channels
//   ctrl_enable               CTRL[0] level
//   ctrl_start                one-cycle pulse when 1 is written to CTRL[1]
//   img_width, img_height     geometry registers [15:0]
//   sts_busy                  live busy flag, readable as STATUS[0]
//   sts_frame_done            frame pulse; sets STATUS[1], bumps STATUS[31:16]
module image_ctl_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            ctrl_enable,
  output logic                            ctrl_start,
  output logic [15:0]                     img_width,
  output logic [15:0]                     img_height,
  input  logic                            sts_busy,
  input  logic                            sts_frame_done
);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_WIDTH  = 2'd1;
  localparam logic [1:0] A_HEIGHT = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  // run keeps every ready low for the first cycle out of reset
  logic        run;
  logic        aw_full;
  logic [1:0]  aw_sel;
  logic        w_full;
  logic [15:0] w_data;
  logic [1:0]  w_strb;
  logic        bvalid;
  logic        rvalid;
  logic [31:0] rdata;
  logic        enable;
  logic        start;
  logic [15:0] width;
  logic [15:0] height;
  logic        done;
  logic [15:0] frame_cnt;

  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        commit;
  logic        wr_ctrl;
  logic        wr_width;
  logic        wr_height;
  logic        wr_status;
  logic        clr_done;
  logic        clr_cnt;
  logic [31:0] rd_word;

  wire unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                     S_AXI_AWADDR, S_AXI_ARADDR,
                     S_AXI_WDATA[31:16],
                     S_AXI_WSTRB[3:2]};

  assign S_AXI_AWREADY = run & ~aw_full;
  assign S_AXI_WREADY  = run & ~w_full;
  assign S_AXI_ARREADY = run & ~rvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = 2'b00;

  assign ctrl_enable = enable;
  assign ctrl_start  = start;
  assign img_width   = width;
  assign img_height  = height;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // a held write waits until the previous response is taken
  assign commit = aw_full & w_full & ~bvalid;

  assign wr_ctrl   = commit & (aw_sel == A_CTRL);
  assign wr_width  = commit & (aw_sel == A_WIDTH);
  assign wr_height = commit & (aw_sel == A_HEIGHT);
  assign wr_status = commit & (aw_sel == A_STATUS);

  assign clr_done = wr_status & w_strb[0] & w_data[1];
  assign clr_cnt  = wr_status & w_strb[0] & w_data[2];

  always_comb begin
    rd_word = '0;
    unique case (S_AXI_ARADDR[3:2])
      A_CTRL:   rd_word[0]    = enable;
      A_WIDTH:  rd_word[15:0] = width;
      A_HEIGHT: rd_word[15:0] = height;
      A_STATUS: rd_word = {frame_cnt, 14'd0,
                           done, sts_busy};
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      run       <= 1'b0;
      aw_full   <= 1'b0;
      aw_sel    <= '0;
      w_full    <= 1'b0;
      w_data    <= '0;
      w_strb    <= '0;
      bvalid    <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      enable    <= 1'b0;
      start     <= 1'b0;
      width     <= '0;
      height    <= '0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      run   <= 1'b1;
      start <= wr_ctrl & w_strb[0] & w_data[1];

      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_sel  <= S_AXI_AWADDR[3:2];
      end else if (commit) begin
        aw_full <= 1'b0;
      end

      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA[15:0];
        w_strb <= S_AXI_WSTRB[1:0];
      end else if (commit) begin
        w_full <= 1'b0;
      end

      if (commit)
        bvalid <= 1'b1;
      else if (S_AXI_BREADY)
        bvalid <= 1'b0;

      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= rd_word;
      end else if (S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end

      if (wr_ctrl & w_strb[0])
        enable <= w_data[0];

      if (wr_width & w_strb[0])
        width[7:0] <= w_data[7:0];
      if (wr_width & w_strb[1])
        width[15:8] <= w_data[15:8];

      if (wr_height & w_strb[0])
        height[7:0] <= w_data[7:0];
      if (wr_height & w_strb[1])
        height[15:8] <= w_data[15:8];

      // a frame arriving with the clear still leaves done set
      done <= sts_frame_done | (done & ~clr_done);

      // clear first, then count this edge's frame
      frame_cnt <= (clr_cnt ? 16'd0 : frame_cnt)
                 + {15'd0, sts_frame_done};
    end
  end

endmodule
